load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the data-memory word-address width.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clock input 1 (all state on rising edge).
REQ-003 reset input 1 asynchronous active-high reset.
REQ-004 req_valid input 1 core request present.
REQ-005 req_ready output 1 block can accept a request.
REQ-006 req_we input 1 1=store, 0=load.
REQ-007 req_funct3 input 3 RV32I width/sign code (LB/LH/LW/LBU/LHU; SB/SH/SW).
REQ-008 req_addr input 32 byte address.
REQ-009 req_wdata input 32 store data, LSB-aligned.
REQ-010 resp_valid output 1 one-cycle completion pulse.
REQ-011 resp_rdata output 32 extended load data; 0 for stores and errors.
REQ-012 resp_err output 1 misaligned or illegal funct3, qualified by resp_valid.
REQ-013 mem_address output ADDR_W word address to data memory.
REQ-014 mem_data output 32 write data to data memory.
REQ-015 mem_wren output 1 write enable to data memory.
REQ-016 mem_q input 32 combinational read data for mem_address.

Function
REQ-017 States SHALL be IDLE, ACCESS, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept = req_valid & req_ready at an edge; the block SHALL latch we, funct3, addr, wdata.
REQ-019 mem_address SHALL equal latched addr[ADDR_W+1:2]; higher address bits ignored (wrap-around).
REQ-020 Misaligned (H at addr[0]=1, W at addr[1:0]!=0) or illegal funct3 SHALL go IDLE->RESP with resp_err=1 and no memory access.
REQ-021 Load: IDLE->ACCESS->RESP; at the ACCESS edge the selected byte/half of mem_q SHALL be sign- (LB/LH) or zero- (LBU/LHU) extended into resp_rdata; resp_valid asserts 2 cycles after accept.
REQ-022 SW: ACCESS SHALL drive mem_wren=1, mem_data=wdata, then RESP.
REQ-023 SB/SH: ACCESS SHALL capture mem_q and merge the low byte/half of wdata into the lane selected by addr[1:0]; WRITE SHALL drive mem_wren=1 with the merged word, then RESP (latency 3).
REQ-024 mem_wren SHALL be 0 in all states except the write cycle of REQ-022/023.
REQ-025 RESP SHALL last exactly one cycle and return to IDLE; no back-pressure on resp.
REQ-026 req_* inputs outside IDLE SHALL be ignored.

Reset
REQ-027 Reset SHALL force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_wren=0, mem_address=0, mem_data=0.
REQ-028 Reset during ACCESS or WRITE SHALL abort the operation with no memory write and no response.

Structure
REQ-029 Package lsu_pkg SHALL hold funct3 constants and the state enumeration.
REQ-030 Combinational sub-module lsu_align SHALL perform lane extraction/extension and store merge.

Verification
REQ-031 SW 0xDEADBEEF @0x10, then LW @0x10 -> word 4 written once; resp_rdata=0xDEADBEEF, resp_err=0.
REQ-032 Word 0x11223344 @0x20; SB 0xAA @0x21 -> mem word 0x1122AA44, mem_wren high exactly one cycle, latency 3.
REQ-033 Word 0x000080F0 @0x0: LB @0x0 -> 0xFFFFFFF0; LBU -> 0x000000F0; LH @0x0 -> 0xFFFF80F0; LHU -> 0x000080F0.
REQ-034 LW @0x13, SH @0x01 -> resp_err=1, resp_rdata=0, mem_wren never asserted.
REQ-035 Assert reset in WRITE of an SB -> mem_wren stays 0, no resp_valid, IDLE with req_ready=1.
REQ-036 Back-to-back req_valid held high -> only one accept per IDLE visit; address 0x400 (ADDR_W=8) maps to word 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - controller state enumeration
//   - req_is_bad(): flags misaligned or illegal-funct3 requests
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
    localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
    localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
    localparam logic [2:0] F3_BU = 3'b100;  // LBU (load only)
    localparam logic [2:0] F3_HU = 3'b101;  // LHU (load only)

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WRITE  = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Returns 1 when the request must be answered with an error and no memory access.
    function automatic logic req_is_bad(input logic i_we, input logic [2:0] i_f3,
                                        input logic [1:0] i_lo);
        logic v_bad;
        case (i_f3)
            F3_B:    v_bad = 1'b0;
            F3_H:    v_bad = i_lo[0];
            F3_W:    v_bad = (i_lo != 2'b00);
            F3_BU:   v_bad = i_we;              // no unsigned store forms
            F3_HU:   v_bad = i_we | i_lo[0];
            default: v_bad = 1'b1;
        endcase
        return v_bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
//   i_funct3     : access width/sign code
//   i_addr_lo    : byte offset within the word
//   i_rdata      : word read from memory
//   i_wdata      : store data, LSB-aligned
//   o_load_data  : selected lane, sign- or zero-extended
//   o_store_data : i_rdata with the low byte/half of i_wdata merged into the selected lane
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_store_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction and extension for loads.
    always_comb begin
        w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_rdata;
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = 32'h0000_0000;
        endcase
    end

    // Read-modify-write merge for sub-word stores.
    always_comb begin
        o_store_data = i_rdata;
        case (i_funct3)
            F3_B:    o_store_data[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            F3_H:    o_store_data[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            F3_W:    o_store_data = i_wdata;
            default: o_store_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding RV32I load/store controller for a
// word-addressed data memory with combinational read data.
//   clock, reset                 : clock, async active-high reset
//   req_valid/req_ready          : request handshake (ready only in IDLE)
//   req_we/req_funct3/req_addr/req_wdata : request fields
//   resp_valid/resp_rdata/resp_err       : one-cycle response
//   mem_address/mem_data/mem_wren/mem_q  : data memory port
// Loads respond 2 cycles after accept, SW 2, SB/SH 3 (read-modify-write),
// errors 1 with no memory access.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_data,
    output logic              mem_wren,
    input  logic [31:0]       mem_q
);

    lsu_state_e        r_state;
    logic              r_req_ready;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_address;
    logic [31:0]       r_mem_data;
    logic              r_mem_wren;

    logic [31:0]       w_load_data;
    logic [31:0]       w_store_data;
    logic              w_unused_addr;

    // Address bits above the memory range wrap around.
    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    lsu_align u_align (
        .i_funct3     (r_funct3),
        .i_addr_lo    (r_addr_lo),
        .i_rdata      (mem_q),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_data (w_store_data)
    );

    // Controller FSM; all outputs are registered alongside the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b1;
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_addr_lo     <= 2'b00;
            r_wdata       <= 32'h0000_0000;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= 32'h0000_0000;
            r_mem_address <= '0;
            r_mem_data    <= 32'h0000_0000;
            r_mem_wren    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we          <= req_we;
                        r_funct3      <= req_funct3;
                        r_addr_lo     <= req_addr[1:0];
                        r_wdata       <= req_wdata;
                        r_mem_address <= req_addr[ADDR_W+1:2];
                        r_resp_rdata  <= 32'h0000_0000;
                        r_req_ready   <= 1'b0;
                        if (req_is_bad(req_we, req_funct3, req_addr[1:0])) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state <= ST_ACCESS;
                            // SW needs no read, so the write happens during ACCESS.
                            if (req_we && (req_funct3 == F3_W)) begin
                                r_mem_wren <= 1'b1;
                                r_mem_data <= req_wdata;
                            end else begin
                                r_mem_wren <= 1'b0;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (!r_we) begin
                        r_resp_rdata <= w_load_data;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else if (r_funct3 == F3_W) begin
                        r_mem_wren   <= 1'b0;
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                    end else begin
                        r_mem_data <= w_store_data;
                        r_mem_wren <= 1'b1;
                        r_state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    r_mem_wren   <= 1'b0;
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_ready  <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_mem_wren   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_err    = r_resp_err;
    assign resp_rdata  = r_resp_rdata;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_wren    = r_mem_wren;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the stimulus thread pushes the
// expected response (error flag, read data, response cycle) per request, and
// an independent monitor pops and compares on every resp_valid.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    logic [31:0] mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h0;
    logic [31:0] pl_data = 32'h0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wren_cnt = 0;

    load_store_unit #(.ADDR_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q)
    );

    always #5 clock = ~clock;

    assign mem_q = mem[mem_address];

    // Data memory model with a bench-side preload port.
    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_wren) mem[mem_address] <= mem_data;
    end

    // Cycle counter and write-pulse counter.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_wren) wren_cnt <= wren_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor.
    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic wait_ready();
        int g = 0;
        @(negedge clock);
        while (!req_ready && g < 20) begin
            @(negedge clock);
            g++;
        end
        check("ready_wait", {31'b0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic err, input logic [31:0] rd,
                         input int lat);
        exp_t e;
        wait_ready();
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        e.err = err; e.rdata = rd; e.cyc = cyc + lat;
        exp_q.push_back(e);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 20) begin
            @(negedge clock);
            g++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        int w0;
        int k;
        exp_t e;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_wren", {31'b0, mem_wren}, 32'd0);
        check("rst_mem_address", {24'b0, mem_address}, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        reset = 1'b0;

        // SW then LW
        w0 = wren_cnt;
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2);
        drain();
        check("sw_mem", mem[4], 32'hDEADBEEF);
        check("sw_wren_cnt", wren_cnt - w0, 32'd1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 2);
        issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFEF, 2);
        issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 2);
        drain();

        // SB read-modify-write
        preload(8'd8, 32'h11223344);
        w0 = wren_cnt;
        issue(1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 1'b0, 32'h0, 3);
        drain();
        check("sb_mem", mem[8], 32'h1122AA44);
        check("sb_wren_cnt", wren_cnt - w0, 32'd1);

        // Load extension
        preload(8'd0, 32'h000080F0);
        issue(1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'hFFFFFFF0, 2);
        issue(1'b0, 3'b100, 32'h0, 32'h0, 1'b0, 32'h000000F0, 2);
        issue(1'b0, 3'b001, 32'h0, 32'h0, 1'b0, 32'hFFFF80F0, 2);
        issue(1'b0, 3'b101, 32'h0, 32'h0, 1'b0, 32'h000080F0, 2);
        issue(1'b0, 3'b000, 32'h1, 32'h0, 1'b0, 32'hFFFFFF80, 2);
        issue(1'b0, 3'b100, 32'h3, 32'h0, 1'b0, 32'h00000000, 2);
        issue(1'b0, 3'b001, 32'h2, 32'h0, 1'b0, 32'h00000000, 2);
        drain();
        issue(1'b1, 3'b001, 32'h2, 32'h1234BEEF, 1'b0, 32'h0, 3);
        drain();
        check("sh_mem", mem[0], 32'hBEEF80F0);

        // Misaligned and illegal funct3
        w0 = wren_cnt;
        issue(1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, 3'b001, 32'h01, 32'hFFFF, 1'b1, 32'h0, 1);
        issue(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, 3'b100, 32'h00, 32'h0, 1'b1, 32'h0, 1);
        drain();
        check("err_wren_cnt", wren_cnt - w0, 32'd0);
        check("err_mem0", mem[0], 32'hBEEF80F0);

        // Reset during WRITE of an SB
        preload(8'd12, 32'h55555555);
        w0 = wren_cnt;
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'h77;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        check("write_wren_high", {31'b0, mem_wren}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_wren", {31'b0, mem_wren}, 32'd0);
        check("abort_ready", {31'b0, req_ready}, 32'd1);
        check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_wren_cnt", wren_cnt - w0, 32'd0);
        check("abort_mem", mem[12], 32'h55555555);

        // Back-to-back with req_valid held; 0x400 wraps to word 0
        preload(8'd0, 32'hCAFE0001);
        wait_ready();
        k = cyc;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h400; req_wdata = 32'h0;
        for (int i = 0; i < 3; i++) begin
            e.err = 1'b0; e.rdata = 32'hCAFE0001; e.cyc = k + 2 + 3 * i;
            exp_q.push_back(e);
        end
        repeat (9) @(negedge clock);
        req_valid = 1'b0;
        drain();
        repeat (4) @(negedge clock);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
